// File: rtl/mesm6_bus_arbiter_if.sv
// Bundle of the two master request/response links and the shared bus port
// between the mesm6 bus arbiter and its surroundings.
interface mesm6_bus_arbiter_if;
  logic [14:0] m0_addr;
  logic        m0_read;
  logic        m0_write;
  logic [47:0] m0_wdata;
  logic [47:0] m0_rdata;
  logic        m0_done;
  logic        m0_err;

  logic [14:0] m1_addr;
  logic        m1_read;
  logic        m1_write;
  logic [47:0] m1_wdata;
  logic [47:0] m1_rdata;
  logic        m1_done;
  logic        m1_err;

  logic [14:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [47:0] bus_wdata;
  logic [47:0] bus_rdata;
  logic        bus_done;
  logic        bus_timeout;

  // Handshake: a master raises read/write with stable addr/wdata and holds them
  // until it sees its one-cycle done pulse (err qualifies done, rdata is valid
  // with done); the bus side holds its strobe until bus_done or an abort.
  modport slave (
    input  m0_addr, m0_read, m0_write, m0_wdata,
    output m0_rdata, m0_done, m0_err,
    input  m1_addr, m1_read, m1_write, m1_wdata,
    output m1_rdata, m1_done, m1_err,
    output bus_addr, bus_read, bus_write, bus_wdata, bus_timeout,
    input  bus_rdata, bus_done
  );

  modport master (
    output m0_addr, m0_read, m0_write, m0_wdata,
    input  m0_rdata, m0_done, m0_err,
    output m1_addr, m1_read, m1_write, m1_wdata,
    input  m1_rdata, m1_done, m1_err,
    input  bus_addr, bus_read, bus_write, bus_wdata, bus_timeout,
    output bus_rdata, bus_done
  );
endinterface

// File: rtl/mesm6_bus_arbiter.sv
// Round-robin arbiter for two masters sharing one bus port: registered bus
// strobes, completion routed to the owner only, and a watchdog abort.
module mesm6_bus_arbiter #(
  parameter int  TIMEOUT = 255,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  mesm6_bus_arbiter_if.slave bif,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          grant;
  logic          last;
  logic          winner;
  logic          start;
  logic [CW-1:0] cnt;
  logic [14:0]   addr_q;
  logic [47:0]   wdata_q;
  logic          read_q;
  logic          write_q;
  logic          req0;
  logic          req1;
  logic          done_ok;
  logic          abort;

  assign req0      = bif.m0_read | bif.m0_write;
  assign req1      = bif.m1_read | bif.m1_write;
  assign dbg_state = state;

  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.bus_read  = read_q;
  assign bif.bus_write = write_q;

  always_comb begin
    state_nxt       = state;
    start           = 1'b0;
    done_ok         = 1'b0;
    abort           = 1'b0;
    bif.m0_done     = 1'b0;
    bif.m0_err      = 1'b0;
    bif.m0_rdata    = '0;
    bif.m1_done     = 1'b0;
    bif.m1_err      = 1'b0;
    bif.m1_rdata    = '0;
    bif.bus_timeout = 1'b0;
    // On a tie the master that did not win last time goes next.
    winner          = (req0 && req1) ? ~last : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // bus_done beats the watchdog when both land in the same cycle.
        if (bif.bus_done) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        abort     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bif.bus_timeout = abort;
    if (!grant) begin
      bif.m0_done  = done_ok | abort;
      bif.m0_err   = abort;
      bif.m0_rdata = done_ok ? bif.bus_rdata : '0;
    end else begin
      bif.m1_done  = done_ok | abort;
      bif.m1_err   = abort;
      bif.m1_rdata = done_ok ? bif.bus_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant   <= winner;
        last    <= winner;
        cnt     <= '0;
        addr_q  <= winner ? bif.m1_addr  : bif.m0_addr;
        wdata_q <= winner ? bif.m1_wdata : bif.m0_wdata;
        write_q <= winner ? bif.m1_write : bif.m0_write;
        // Read together with write collapses to a write.
        read_q  <= winner ? (bif.m1_read & ~bif.m1_write)
                          : (bif.m0_read & ~bif.m0_write);
      end else if (state == BUSY) begin
        cnt <= cnt + CW'(1);
        if (state_nxt != BUSY) begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      end
    end
  end

endmodule
